// File: rtl/pcm_out_pkg.sv
// Shared types and constants for the PCM audio output stage.
package pcm_out_pkg;

    localparam int unsigned PWM_BITS = 8;

    typedef logic [PWM_BITS-1:0] pcm_t;

    localparam pcm_t PCM_SILENCE = 8'h80;

endpackage

// File: rtl/pcm_pwm_out_if.sv
// Valid/ready stream carrying unsigned 8-bit PCM samples into the output stage.
interface pcm_pwm_out_if;
    import pcm_out_pkg::*;

    pcm_t in_data;
    logic in_vld;
    logic in_rdy;

    modport master (output in_data, output in_vld, input in_rdy);
    modport slave  (input in_data, input in_vld, output in_rdy);

endinterface

// File: rtl/pcm_fifo.sv
// Small synchronous sample FIFO, power-of-two depth, no fall-through.
module pcm_fifo
    import pcm_out_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  pcm_t                       wdata_i,
    input  logic                       pop_i,
    output pcm_t                       rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = DEPTH[AW:0];

    pcm_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == Full);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pcm_pwm_out.sv
// Paced PCM output stage: FIFO-buffered samples drive a PWM (or, with
// PCM_OUT_SIGMA_DELTA_EN defined, a first-order delta-sigma) audio bit.
module pcm_pwm_out
    import pcm_out_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SAMPLE_PERIODS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    pcm_pwm_out_if.slave                  in_if,
    output logic                          pwm_out,
    output pcm_t                          sample_out,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underrun,
    input  logic                          clr_underrun
);

    localparam logic [7:0] RepLast = 8'(SAMPLE_PERIODS - 1);

    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] rep_cnt_q, rep_cnt_d;
    pcm_t       sample_q, sample_d;
    logic       pwm_q, pwm_d;
    logic       underrun_q, underrun_d;
    logic       wrap, tick, push, pop;
    logic       fifo_full, fifo_empty;
    pcm_t       fifo_head;

    pcm_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (in_if.in_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_if.in_rdy = !fifo_full;
    assign pwm_out      = pwm_q;
    assign sample_out   = sample_q;
    assign underrun     = underrun_q;

`ifdef PCM_OUT_SIGMA_DELTA_EN
    logic [7:0] acc_q, acc_d;
    logic [8:0] sd_sum;
`endif

    always_comb begin
        wrap      = ena && (pwm_cnt_q == 8'hFF);
        tick      = wrap && (rep_cnt_q == RepLast);
        push      = in_if.in_vld && !fifo_full;
        pop       = tick && !fifo_empty;
        pwm_cnt_d = ena ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        rep_cnt_d = rep_cnt_q;
        if (wrap) begin
            rep_cnt_d = (rep_cnt_q == RepLast) ? 8'd0 : rep_cnt_q + 8'd1;
        end
        sample_d = pop ? fifo_head : sample_q;
        // A starving tick takes priority over a simultaneous clear.
        if (tick && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
`ifdef PCM_OUT_SIGMA_DELTA_EN
        sd_sum = {1'b0, acc_q} + {1'b0, sample_q};
        acc_d  = ena ? sd_sum[7:0] : acc_q;
        pwm_d  = ena && sd_sum[8];
`else
        pwm_d  = ena && (pwm_cnt_q < sample_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            sample_q   <= PCM_SILENCE;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            sample_q   <= sample_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef PCM_OUT_SIGMA_DELTA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

endmodule
